// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared defaults for the synchronous FIFO and its storage sub-module.
//   DEFAULT_DATA  : word width in bits
//   DEFAULT_ADDR  : address width in bits
//   DEFAULT_DEPTH : number of entries, always 2**DEFAULT_ADDR
package sync_fifo_pkg;
    localparam int DEFAULT_DATA  = 8;
    localparam int DEFAULT_ADDR  = 4;
    localparam int DEFAULT_DEPTH = 1 << DEFAULT_ADDR;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
// DEPTH x DATA register array with one synchronous write port and one
// synchronous, registered read port. The storage array is never reset;
// only the read register is.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears rdata only
//   wr    : write strobe (already qualified by the caller)
//   waddr : write index
//   wdata : write data
//   rd    : read strobe (already qualified by the caller)
//   raddr : read index
//   rdata : registered read data, changes only on rd or rst
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA  = DEFAULT_DATA,
    parameter int ADDR  = DEFAULT_ADDR,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [ADDR-1:0] waddr,
    input  logic [DATA-1:0] wdata,
    input  logic            rd,
    input  logic [ADDR-1:0] raddr,
    output logic [DATA-1:0] rdata
);

    logic [DATA-1:0] mem [DEPTH];

    // Storage has no reset so it maps onto plain registers / RAM.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO of DEPTH words of DATA bits with registered read data.
// Writes to a full FIFO and reads from an empty FIFO are silently dropped.
//
// Request semantics: wr_en and rd_en are sampled at each rising edge and
// qualified against the flags as they stood before that edge. A write is
// accepted when wr_en && !full, a read when rd_en && !empty; rejected
// requests leave every piece of state untouched. Read data appears on dout
// one cycle after the accepting edge.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, dominates wr_en/rd_en
//   wr_en : write request
//   rd_en : read request
//   din   : write data
//   dout  : registered read data
//   full  : DEPTH entries held
//   empty : no entries held
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA  = DEFAULT_DATA,
    parameter int ADDR  = DEFAULT_ADDR,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [DATA-1:0] din,
    output logic [DATA-1:0] dout,
    output logic            full,
    output logic            empty
);

    localparam logic [ADDR:0] PTR_ONE = {{ADDR{1'b0}}, 1'b1};

    // One extra MSB per pointer acts as a wrap bit so that equal indices
    // can be told apart as "empty" (same lap) or "full" (one lap apart).
    logic [ADDR:0] wr_ptr;
    logic [ADDR:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]) &&
                   (wr_ptr[ADDR] != rd_ptr[ADDR]);

    // Reset wins over both requests, so no memory write slips through
    // on a reset edge.
    assign wr_acc = wr_en && !full  && !rst;
    assign rd_acc = rd_en && !empty && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    sync_fifo_mem #(
        .DATA  (DATA),
        .ADDR  (ADDR),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr_acc),
        .waddr (wr_ptr[ADDR-1:0]),
        .wdata (din),
        .rd    (rd_acc),
        .raddr (rd_ptr[ADDR-1:0]),
        .rdata (dout)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
// Directed bench for sync_fifo with default parameters (8 x 16).
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;

    int vectors;
    int miscompares;

    sync_fifo #(8, 4, 16) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one clock edge with the given request pins, observed 1 time unit later
    task automatic cycle(input logic r, input logic w, input logic rd, input logic [7:0] d);
        rst   = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] wv [5];
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 8'h00;
        wv[0] = 8'h24; wv[1] = 8'h81; wv[2] = 8'h09; wv[3] = 8'h63; wv[4] = 8'h0d;

        // reset held for two edges
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_dout",  dout,  8'h00);
        check("rst_empty", {7'd0, empty}, 8'h01);
        check("rst_full",  {7'd0, full},  8'h00);

        // write 5 then read 5
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, wv[i]);
            check("wr5_empty", {7'd0, empty}, 8'h00);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("wr5_idle_empty", {7'd0, empty}, 8'h00);
        check("wr5_idle_full",  {7'd0, full},  8'h00);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            check("rd5_dout", dout, wv[i]);
        end
        check("rd5_empty", {7'd0, empty}, 8'h01);

        // fill: full must rise exactly on the 16th write
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i));
            check("fill_full", {7'd0, full}, (i == 15) ? 8'h01 : 8'h00);
        end
        cycle(1'b0, 1'b1, 1'b0, 8'hFF);
        check("ovf_full", {7'd0, full}, 8'h01);
        check("ovf_wr_ptr", 8'(dut.wr_ptr), 8'd21);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            check("drain_dout", dout, 8'hA0 + 8'(i));
            check("drain_full", {7'd0, full}, 8'h00);
        end
        check("drain_empty", {7'd0, empty}, 8'h01);

        // underflow: reads while empty change nothing
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            check("unf_dout",  dout, 8'hAF);
            check("unf_empty", {7'd0, empty}, 8'h01);
        end
        check("unf_rd_ptr", 8'(dut.rd_ptr), 8'd21);
        check("unf_wr_ptr", 8'(dut.wr_ptr), 8'd21);

        // simultaneous read/write with 3 held, crossing the index wrap
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'hC0 + 8'(i));
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 8'hC3 + 8'(i));
            check("rw_dout",  dout, 8'hC0 + 8'(i));
            check("rw_empty", {7'd0, empty}, 8'h00);
            check("rw_full",  {7'd0, full},  8'h00);
        end
        // 21 + 13 writes = 34 -> 2 mod 32 ; 21 + 10 reads = 31
        check("rw_wr_ptr", 8'(dut.wr_ptr), 8'd2);
        check("rw_rd_ptr", 8'(dut.rd_ptr), 8'd31);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            check("rw_drain_dout", dout, 8'hCA + 8'(i));
        end
        check("rw_drain_empty", {7'd0, empty}, 8'h01);

        // both requests while empty: only the write happens, no bypass
        cycle(1'b0, 1'b1, 1'b1, 8'h77);
        check("e_rw_empty", {7'd0, empty}, 8'h00);
        check("e_rw_dout",  dout, 8'hCC);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check("e_rw_rd_dout", dout, 8'h77);
        check("e_rw_rd_empty", {7'd0, empty}, 8'h01);

        // mid-operation reset with 8 held; requests during reset are ignored
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h50 + 8'(i));
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check("pre_rst_dout", dout, 8'h50);
        cycle(1'b1, 1'b1, 1'b1, 8'hEE);
        check("mid_rst_empty", {7'd0, empty}, 8'h01);
        check("mid_rst_full",  {7'd0, full},  8'h00);
        check("mid_rst_dout",  dout, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h5a);
        check("post_rst_empty", {7'd0, empty}, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check("post_rst_dout",  dout, 8'h5a);
        check("post_rst_empty2", {7'd0, empty}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
